// File: rtl/iir_mac_sched_pkg.sv
// Shared types and constants for the time-multiplexed 2nd-order IIR scheduler.
package iir_mac_sched_pkg;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, RND} state_e;

  localparam logic [1:0] CFG_A1 = 2'd0;
  localparam logic [1:0] CFG_B1 = 2'd1;
  localparam logic [1:0] CFG_B2 = 2'd2;

  localparam logic [7:0] A1_DEF = 8'hEE;
  localparam logic [7:0] B1_DEF = 8'h51;
  localparam logic [7:0] B2_DEF = 8'hDE;

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] b1;
    logic [7:0] b2;
  } coef_t;

  // Upper byte, bumped by one when the sign and bit 7 disagree; wraps in 8 bits.
  function automatic logic [7:0] rnd8(input logic [15:0] acc);
    return acc[15:8] + {7'b0, acc[15] ^ acc[7]};
  endfunction

endpackage

// File: rtl/iir_mac_sched_if.sv
// Sample handshake, coefficient write port and filter output of the IIR scheduler.
interface iir_mac_sched_if;
  logic signed [7:0] x;
  logic              x_valid;
  logic              x_ready;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [7:0]        cfg_data;
  logic [7:0]        y;
  logic              y_valid;

  modport master (output x, x_valid, cfg_we, cfg_addr, cfg_data,
                  input  x_ready, y, y_valid);
  modport slave  (input  x, x_valid, cfg_we, cfg_addr, cfg_data,
                  output x_ready, y, y_valid);
endinterface

// File: rtl/iir_mac_sched_mac8.sv
// Single shared 8x8 signed multiplier with a 16-bit wrapping accumulator.
module iir_mac_sched_mac8 (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  input  logic              clr,
  input  logic              en,
  output logic [15:0]       acc
);
  logic signed [15:0] prod;
  logic [15:0]        acc_d, acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr)     acc_d = prod;
    else if (en) acc_d = acc_q + prod;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/iir_mac_sched.sv
// IIR section y = a1*x + b1*y[n-1] + b2*y[n-2], one product per cycle, 5 clk per sample.
module iir_mac_sched
  import iir_mac_sched_pkg::*;
#(
  parameter logic [7:0] A1_INIT = A1_DEF,
  parameter logic [7:0] B1_INIT = B1_DEF,
  parameter logic [7:0] B2_INIT = B2_DEF
) (
  input logic            clk,
  input logic            reset,
  iir_mac_sched_if.slave bus
);
  localparam coef_t COEF_INIT = '{a1: A1_INIT, b1: B1_INIT, b2: B2_INIT};

  state_e            state_d, state_q;
  logic signed [7:0] xs_d, xs_q;
  logic [7:0]        y_d, y_q, y2_d, y2_q;
  logic              yv_d, yv_q;
  coef_t             sh_d, sh_q, act_d, act_q;

  logic              x_ready, accept;
  logic signed [7:0] op_a, op_b;
  logic              mac_clr, mac_en;
  logic [15:0]       acc;

  assign x_ready = (state_q == IDLE) && !reset;
  assign accept  = bus.x_valid && x_ready;

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    y_d     = y_q;
    y2_d    = y2_q;
    yv_d    = 1'b0;
    sh_d    = sh_q;
    act_d   = act_q;
    op_a    = act_q.a1;
    op_b    = xs_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        CFG_A1:  sh_d.a1 = bus.cfg_data;
        CFG_B1:  sh_d.b1 = bus.cfg_data;
        CFG_B2:  sh_d.b2 = bus.cfg_data;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: if (accept) begin
        xs_d    = bus.x;
        act_d   = sh_d;  // a write landing on the accept cycle is already visible
        state_d = MAC0;
      end
      MAC0: begin
        mac_clr = 1'b1;
        state_d = MAC1;
      end
      MAC1: begin
        op_a    = act_q.b1;
        op_b    = y_q;
        mac_en  = 1'b1;
        state_d = MAC2;
      end
      MAC2: begin
        op_a    = act_q.b2;
        op_b    = y2_q;
        mac_en  = 1'b1;
        state_d = RND;
      end
      RND: begin
        y_d     = rnd8(acc);
        y2_d    = y_q;
        yv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      xs_q    <= '0;
      y_q     <= '0;
      y2_q    <= '0;
      yv_q    <= 1'b0;
      sh_q    <= COEF_INIT;
      act_q   <= COEF_INIT;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      y_q     <= y_d;
      y2_q    <= y2_d;
      yv_q    <= yv_d;
      sh_q    <= sh_d;
      act_q   <= act_d;
    end
  end

  iir_mac_sched_mac8 u_mac (
    .clk  (clk),
    .reset(reset),
    .a    (op_a),
    .b    (op_b),
    .clr  (mac_clr),
    .en   (mac_en),
    .acc  (acc)
  );

  assign bus.x_ready = x_ready;
  assign bus.y       = y_q;
  assign bus.y_valid = yv_q;
endmodule

// File: tb/tb_iir_mac_sched.sv
// Scoreboard bench: a parallel-form filter model queues expected outputs, a monitor checks them.
module tb_iir_mac_sched;
  import iir_mac_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iir_mac_sched_if bus();
  iir_mac_sched dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  logic [7:0] m_sh[3] = '{8'hEE, 8'h51, 8'hDE};
  logic [7:0] m_y = 8'h00, m_y2 = 8'h00;
  int         m_cnt = 0;
  logic       m_yv = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_y(input logic signed [7:0] xv, a1, b1, b2, y1, y2);
    int s;
    logic [15:0] a;
    s = a1 * xv + b1 * y1 + b2 * y2;
    a = s[15:0];
    return a[15:8] + {7'b0, a[15] ^ a[7]};
  endfunction

  // Reference filter: accepts whenever idle, five cycles per sample.
  always @(posedge clk) begin
    logic [7:0] r;
    if (reset) begin
      m_cnt = 0; m_yv = 1'b0; m_y = 8'h00; m_y2 = 8'h00;
      m_sh = '{8'hEE, 8'h51, 8'hDE};
      exp_q.delete();
    end else begin
      if (bus.cfg_we && bus.cfg_addr != 2'd3) m_sh[bus.cfg_addr] = bus.cfg_data;
      m_yv = (m_cnt == 4);
      if (m_cnt == 0) begin
        if (bus.x_valid) begin
          r = ref_y(bus.x, m_sh[0], m_sh[1], m_sh[2], m_y, m_y2);
          exp_q.push_back(r);
          m_y2 = m_y; m_y = r; m_cnt = 1;
        end
      end else if (m_cnt == 4) m_cnt = 0;
      else m_cnt++;
    end
  end

  always @(negedge clk) begin
    chk("x_ready", 16'(bus.x_ready), 16'(m_cnt == 0 && !reset));
    chk("y_valid", 16'(bus.y_valid), 16'(m_yv));
    if (bus.y_valid) begin
      obs_q.push_back(bus.y);
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL y_unexpected: got %h expected none", bus.y);
      end else chk("y", 16'(bus.y), 16'(exp_q.pop_front()));
    end
  end

  task automatic drive_idle();
    bus.x = '0; bus.x_valid = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
  endtask

  task automatic send(input logic [7:0] xv, input logic we = 1'b0,
                      input logic [1:0] ad = 2'd0, input logic [7:0] dt = 8'h00);
    bit done = 0;
    @(negedge clk);
    bus.x = xv; bus.x_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.x_ready) begin
        bus.cfg_we = we; bus.cfg_addr = ad; bus.cfg_data = dt;
        done = 1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    drive_idle();
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got no x_ready expected accept");
    end
  endtask

  task automatic cfg(input logic [1:0] ad, input logic [7:0] dt);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = ad; bus.cfg_data = dt;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; drive_idle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && m_cnt == 0 && !m_yv) done = 1;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_acc_at_rnd(input string nm, input logic [15:0] exp);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(nm, dut.u_mac.acc_q, exp);
  endtask

  // Impulse with default coefficients and cleared history.
  task automatic impulse(input string tag);
    obs_q.delete();
    send(8'd127); check_acc_at_rnd({tag, "_acc0"}, 16'hF712);
    send(8'd0);   check_acc_at_rnd({tag, "_acc1"}, 16'hFD78);
    send(8'd0);   check_acc_at_rnd({tag, "_acc2"}, 16'h006E);
    wait_idle();
    chk({tag, "_count"}, 16'(obs_q.size()), 16'd3);
    if (obs_q.size() == 3) begin
      chk({tag, "_y0"}, 16'(obs_q[0]), 16'h00F8);
      chk({tag, "_y1"}, 16'(obs_q[1]), 16'h00FE);
      chk({tag, "_y2"}, 16'(obs_q[2]), 16'h0000);
    end
  endtask

  initial begin
    logic [7:0] bp_x[4] = '{8'd3, 8'hF0, 8'd100, 8'h81};
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_y", 16'(bus.y), 16'h0);
    chk("rst_yv", 16'(bus.y_valid), 16'h0);
    chk("rst_a1", 16'(dut.sh_q.a1), 16'h00EE);
    chk("rst_b1", 16'(dut.sh_q.b1), 16'h0051);
    chk("rst_b2", 16'(dut.sh_q.b2), 16'h00DE);
    reset = 1'b0;

    impulse("imp");

    // Backpressure: x_valid held, accepts every fifth cycle.
    wait_idle();
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i < 20) begin
        bus.x_valid = 1'b1;
        if (i % 5 == 0) bus.x = bp_x[i / 5];
      end else drive_idle();
      chk("bp_ready", 16'(bus.x_ready), 16'(i % 5 == 0));
      chk("bp_valid", 16'(bus.y_valid), 16'(i % 5 == 0 && i > 0));
    end
    wait_idle();

    // Coefficient write while a sample is in MAC1.
    do_reset();
    obs_q.delete();
    send(8'd127);
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = CFG_A1; bus.cfg_data = 8'h40;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    send(8'd4);
    wait_idle();
    if (obs_q.size() == 2) begin
      chk("mid_y0", 16'(obs_q[0]), 16'h00F8);
      chk("mid_y1", 16'(obs_q[1]), 16'h00FF);
    end else chk("mid_count", 16'(obs_q.size()), 16'd2);

    // Write on the accept cycle takes effect for that sample.
    do_reset();
    obs_q.delete();
    send(8'd2, 1'b1, CFG_A1, 8'h7F);
    check_acc_at_rnd("sim_acc", 16'h00FE);
    send(8'd0);
    wait_idle();
    if (obs_q.size() == 2) begin
      chk("sim_y0", 16'(obs_q[0]), 16'h0001);
      chk("sim_y1", 16'(obs_q[1]), 16'h0000);
    end else chk("sim_count", 16'(obs_q.size()), 16'd2);

    // Reset in MAC1 aborts the sample and restores coefficients.
    send(8'd127);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_state", 16'(dut.state_q), 16'(IDLE));
    chk("abort_y", 16'(bus.y), 16'h0);
    chk("abort_a1", 16'(dut.sh_q.a1), 16'h00EE);
    chk("abort_act", 16'(dut.act_q.a1), 16'h00EE);
    reset = 1'b0;
    obs_q.delete();
    repeat (8) @(negedge clk);
    chk("abort_nopulse", 16'(obs_q.size()), 16'd0);
    impulse("rerun");

    // Reserved address is ignored.
    do_reset();
    cfg(2'd3, 8'hFF);
    chk("rsv_a1", 16'(dut.sh_q.a1), 16'h00EE);
    chk("rsv_b1", 16'(dut.sh_q.b1), 16'h0051);
    chk("rsv_b2", 16'(dut.sh_q.b2), 16'h00DE);
    impulse("rsv");

    // Wrap stress at the most negative input.
    for (int i = 0; i < 5; i++) send(8'h80);
    send(8'd127);
    send(8'h80);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
